// File: rtl/area_bcd_display_pkg.sv
// area_disp_pkg: shared state encoding, default sizes and 7-segment constants
// for the triangle-area BCD display stage.
package area_disp_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int DEF_IN_W   = 21;
    localparam int DEF_DIGITS = 7;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // Decimal digits needed to print 2^bits (log10(2) ~= 0.30103)
    function automatic int min_digits(input int bits);
        return bits * 30103 / 100000 + 1;
    endfunction

endpackage

// File: rtl/area_bcd_display_seg7_decoder.sv
// seg7_decoder: one BCD nibble to active-low 7-segment pattern; non-decimal
// nibbles and blanked digits go dark.
module seg7_decoder
    import area_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg_n
);

    logic [6:0] pattern;

    always_comb begin
        pattern = SEG_BLANK;
        case (nibble)
            4'd0: pattern = SEG_0;
            4'd1: pattern = SEG_1;
            4'd2: pattern = SEG_2;
            4'd3: pattern = SEG_3;
            4'd4: pattern = SEG_4;
            4'd5: pattern = SEG_5;
            4'd6: pattern = SEG_6;
            4'd7: pattern = SEG_7;
            4'd8: pattern = SEG_8;
            4'd9: pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
    end

    assign seg_n = blank ? SEG_BLANK : pattern;

endmodule

// File: rtl/area_bcd_display.sv
// area_bcd_display: |det|/2 with a .5 flag, converted to BCD by serial
// double-dabble (one bit per clock) and decoded for a 7-segment display.
module area_bcd_display
    import area_disp_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  CLOCK_50,
    input  logic                  RST_N,
    input  logic [IN_W-1:0]       det_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  half,
    output logic [7*DIGITS-1:0]   seg_n
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = IN_W - 1;
    localparam int CW = $clog2(IN_W);
    localparam logic [7*DIGITS-1:0] SEG_RST = {{(DIGITS-1){SEG_BLANK}}, SEG_0};

    if (DIGITS < min_digits(IN_W - 2)) begin : g_chk
        $error("area_bcd_display: DIGITS=%0d too small for IN_W=%0d", DIGITS, IN_W);
    end

    state_t             state;
    logic [SW-1:0]      sreg;
    logic [BW-1:0]      work;
    logic [CW-1:0]      cnt;
    logic               half_r;
    logic [IN_W-1:0]    mag;
    logic [BW-1:0]      adj;
    logic [BW-1:0]      nxt_work;
    logic [SW-1:0]      nxt_sreg;
    logic [DIGITS-1:0]  blank;
    logic               lead;
    logic [7*DIGITS-1:0] seg_nxt;

    // Two's-complement negate; the most-negative input maps to 2^(IN_W-1) unsigned
    assign mag = det_in[IN_W-1] ? -det_in : det_in;

    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = (work[4*i +: 4] >= 4'd5) ? work[4*i +: 4] + 4'd3 : work[4*i +: 4];
    end

    assign {nxt_work, nxt_sreg} = {adj[BW-2:0], sreg, 1'b0};

    // Leading-zero blanking scans from the MSD down; digit 0 always lit
    always_comb begin
        blank = '0;
        lead  = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lead     = lead && (nxt_work[4*i +: 4] == 4'd0);
            blank[i] = lead;
        end
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        seg7_decoder u_dec (
            .nibble (nxt_work[4*d +: 4]),
            .blank  (blank[d]),
            .seg_n  (seg_nxt[7*d +: 7])
        );
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sreg      <= '0;
            work      <= '0;
            cnt       <= '0;
            half_r    <= 1'b0;
            bcd       <= '0;
            half      <= 1'b0;
            seg_n     <= SEG_RST;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sreg     <= mag[IN_W-1:1];
                    half_r   <= mag[0];
                    work     <= '0;
                    cnt      <= CW'(IN_W - 1);
                    in_ready <= 1'b0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    work <= nxt_work;
                    sreg <= nxt_sreg;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bcd       <= nxt_work;
                        half      <= half_r;
                        seg_n     <= seg_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_area_bcd_display.sv
// tb_area_bcd_display: table vectors, random determinants against an
// arithmetic reference, plus backpressure and mid-conversion reset sequences.
module tb_area_bcd_display;

    logic        CLOCK_50 = 1'b0;
    logic        RST_N    = 1'b0;
    logic [20:0] det_in   = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, half;
    logic [27:0] bcd;
    logic [48:0] seg_n;

    int n_checks = 0;
    int n_fail   = 0;

    area_bcd_display dut (
        .CLOCK_50  (CLOCK_50),
        .RST_N     (RST_N),
        .det_in    (det_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .half      (half),
        .seg_n     (seg_n)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    localparam logic [6:0] SEG_TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [48:0] SEG_RST = {{6{7'h7F}}, 7'h40};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int unsigned ref_mag(input logic [20:0] det);
        int v;
        v = {{11{det[20]}}, det};
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [27:0] ref_bcd(input int unsigned a);
        logic [27:0] r;
        r = '0;
        for (int i = 0; i < 7; i++) begin
            r[4*i +: 4] = 4'(a % 10);
            a = a / 10;
        end
        return r;
    endfunction

    function automatic logic [48:0] ref_seg(input logic [27:0] b);
        logic [48:0] s;
        int msd;
        msd = 0;
        for (int i = 0; i < 7; i++) if (b[4*i +: 4] != 0) msd = i;
        for (int i = 0; i < 7; i++)
            s[7*i +: 7] = (i > msd) ? 7'h7F : SEG_TBL[b[4*i +: 4]];
        return s;
    endfunction

    task automatic accept(input logic [20:0] det);
        int t;
        t = 0;
        @(negedge CLOCK_50);
        while (!in_ready && t < 50) begin
            @(negedge CLOCK_50);
            t++;
        end
        det_in   = det;
        in_valid = 1'b1;
        @(posedge CLOCK_50);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge CLOCK_50);
            #1 lat++;
        end
        check({name, " latency"}, 64'(lat), 64'd20);
    endtask

    task automatic consume(input string name, input logic [27:0] exp_bcd);
        @(negedge CLOCK_50);
        out_ready = 1'b1;
        @(posedge CLOCK_50);
        #1 out_ready = 1'b0;
        check({name, " idle in_ready"}, 64'(in_ready), 64'd1);
        check({name, " idle out_valid"}, 64'(out_valid), 64'd0);
        check({name, " bcd held"}, 64'(bcd), 64'(exp_bcd));
    endtask

    task automatic run(input string name, input logic [20:0] det,
                       input logic [27:0] exp_bcd, input logic exp_half);
        accept(det);
        wait_done(name);
        check({name, " bcd"}, 64'(bcd), 64'(exp_bcd));
        check({name, " half"}, 64'(half), 64'(exp_half));
        check({name, " seg_n"}, 64'(seg_n), 64'(ref_seg(exp_bcd)));
        consume(name, exp_bcd);
    endtask

    typedef struct {
        string       name;
        logic [20:0] det;
        logic [27:0] bcd;
        logic        half;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{"tri7544", 21'd7544,    28'h0003772, 1'b0};
        vecs[1] = '{"neg7",    21'h1FFFF9,  28'h0000003, 1'b1};
        vecs[2] = '{"mostneg", 21'h100000,  28'h0524288, 1'b0};
        vecs[3] = '{"maxpos",  21'd1048575, 28'h0524287, 1'b1};
        vecs[4] = '{"zero",    21'd0,       28'h0000000, 1'b0};

        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst bcd", 64'(bcd), 64'd0);
        check("rst seg_n", 64'(seg_n), 64'(SEG_RST));
        @(negedge CLOCK_50);
        RST_N = 1'b1;

        for (int i = 0; i < 5; i++)
            run(vecs[i].name, vecs[i].det, vecs[i].bcd, vecs[i].half);
        check("tri7544 digits", 64'(ref_seg(28'h0003772)),
              64'({{3{7'h7F}}, SEG_TBL[3], SEG_TBL[7], SEG_TBL[7], SEG_TBL[2]}));

        for (int i = 0; i < 25; i++) begin
            logic [20:0] d;
            int unsigned m;
            d = 21'($urandom);
            if (i % 5 == 0) d = 21'($urandom_range(0, 99));
            m = ref_mag(d);
            run("rand", d, ref_bcd(m / 2), m[0]);
        end

        accept(21'd7544);
        wait_done("bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            det_in   = 21'd100;
            in_valid = 1'b1;
            check("bp in_ready", 64'(in_ready), 64'd0);
            check("bp out_valid", 64'(out_valid), 64'd1);
            check("bp bcd stable", 64'(bcd), 64'h3772);
        end
        @(negedge CLOCK_50);
        out_ready = 1'b1;
        @(posedge CLOCK_50);
        #1 out_ready = 1'b0;
        check("bp retire in_ready", 64'(in_ready), 64'd1);
        check("bp retire out_valid", 64'(out_valid), 64'd0);
        @(posedge CLOCK_50);
        #1 in_valid = 1'b0;
        check("bp accepted", 64'(in_ready), 64'd0);
        wait_done("bp100");
        check("bp100 bcd", 64'(bcd), 64'h50);
        check("bp100 half", 64'(half), 64'd0);
        consume("bp100", 28'h50);

        accept(21'd7544);
        repeat (4) @(posedge CLOCK_50);
        #2 RST_N = 1'b0;
        #1;
        check("midrst in_ready", 64'(in_ready), 64'd1);
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst bcd", 64'(bcd), 64'd0);
        check("midrst half", 64'(half), 64'd0);
        check("midrst seg_n", 64'(seg_n), 64'(SEG_RST));
        repeat (3) @(posedge CLOCK_50);
        #1 check("midrst hold", 64'(out_valid), 64'd0);
        @(negedge CLOCK_50);
        RST_N = 1'b1;
        run("postrst", 21'h1FFFF9, 28'h3, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
